// File: rtl/vscale_pkg.sv
// vscale_pkg: constants shared across the vscale front end.
//   XLEN_DEFAULT  default address / instruction width
//   RV_NOP        canonical RISC-V no-op (addi x0, x0, 0)
package vscale_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] RV_NOP       = 32'h0000_0013;

endpackage

// File: rtl/vscale_sync_fifo.sv
// vscale_sync_fifo: synchronous FIFO with flush; head is read combinationally.
//   hclk, reset        clock, asynchronous active-high reset
//   push, push_data    write an entry (caller guarantees space)
//   pop, pop_data      remove the head; pop_data is the current head
//   flush              discard all entries; wins over same-cycle push/pop
//   full, empty, count occupancy status
module vscale_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   hclk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge hclk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
            count <= count + cnt_t'(push) - cnt_t'(pop);
        end
    end

    // NOTE: the storage array has no reset; entries are only observable
    // through count/empty, which are reset, so clearing it buys nothing.
    always_ff @(posedge hclk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);

endmodule

// File: rtl/vscale_fetch_queue.sv
// vscale_fetch_queue: instruction fetch unit with a credit-controlled queue.
//   hclk, reset                    clock, asynchronous active-high reset
//   redirect_valid, redirect_pc    flush the queue and restart fetch
//   imem_req/addr/gnt              request channel to instruction memory
//   imem_rvalid/rdata              in-order response channel
//   inst_valid/inst/inst_pc        queue head towards the decoder
//   inst_ready                     decoder accepts the head
module vscale_fetch_queue
    import vscale_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            hclk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef logic [CW-1:0] ctr_t;
    typedef logic [CW:0]   credit_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } entry_t;

    localparam credit_t DEPTH_C = credit_t'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] restart_pc;
    ctr_t            inflight;
    ctr_t            inflight_next;
    ctr_t            discard;
    ctr_t            fifo_count;
    credit_t         credit_used;
    logic            fire;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    entry_t          head;

    assign restart_pc = redirect_pc & ~XLEN'(3);

    // Every granted request owns a queue slot until it is popped or dropped,
    // so the queue can never be asked to hold more than DEPTH entries.
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    assign imem_req    = !reset && !redirect_valid && (credit_used < DEPTH_C);
    assign imem_addr   = fetch_pc;

    assign fire          = imem_req && imem_gnt;
    assign push          = imem_rvalid && (discard == '0);
    assign pop           = inst_valid && inst_ready;
    assign inflight_next = inflight + ctr_t'(fire) - ctr_t'(imem_rvalid);

    always_ff @(posedge hclk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect_valid) begin
                // Everything still outstanding after this cycle belongs to the
                // old stream; a same-cycle response is already in inflight_next.
                fetch_pc <= restart_pc;
                resp_pc  <= restart_pc;
                discard  <= inflight_next;
            end else begin
                if (fire) fetch_pc <= fetch_pc + XLEN'(4);
                if (push) resp_pc <= resp_pc + XLEN'(4);
                else if (imem_rvalid) discard <= discard - ctr_t'(1);
            end
        end
    end

    vscale_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .hclk      (hclk),
        .reset     (reset),
        .push      (push),
        .push_data ({resp_pc, imem_rdata}),
        .pop       (pop),
        .pop_data  (head),
        .flush     (redirect_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign inst_valid = !fifo_empty;
    assign inst_pc    = head.pc;
    assign inst       = inst_valid ? head.word : XLEN'(RV_NOP);

    a_no_push_when_full: assert property (
        @(posedge hclk) disable iff (reset) push |-> !fifo_full);
    a_discard_bounded: assert property (
        @(posedge hclk) disable iff (reset) discard <= inflight);
    a_rvalid_expected: assert property (
        @(posedge hclk) disable iff (reset) imem_rvalid |-> (inflight != '0));

endmodule

// File: tb/tb_vscale_fetch_queue.sv
module tb_vscale_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic            hclk = 1'b0;
    logic            reset = 1'b1;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt = 1'b0;
    logic            imem_rvalid = 1'b0;
    logic [XLEN-1:0] imem_rdata = '0;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready = 1'b0;

    vscale_fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .hclk           (hclk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 hclk = ~hclk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Memory model: in-order responses, latency chosen per grant.
    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    pend_t       pend[$];
    int unsigned cyc = 0;
    int unsigned last_due = 0;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;

    // Reference model: after a restart at address A, fetches and deliveries
    // are simply A, A+4, A+8, ... and each delivered word is inst_of(pc).
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    int          pops = 0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_inst;

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        inst_ready     = 1'b0;
        pend.delete();
        repeat (2) @(posedge hclk);
        #1 reset = 1'b0;
        cyc       = 0;
        last_due  = 0;
        exp_fetch = RESET_PC;
        exp_pc    = RESET_PC;
    endtask

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic tick();
        int unsigned due;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = inst_of(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        @(negedge hclk);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = inst_valid;
        s_pc    = inst_pc;
        s_inst  = inst;
        if (redirect_valid) check("req_during_redirect", imem_req, 0);
        if (imem_req && imem_gnt) begin
            check("grant_addr", imem_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{addr: imem_addr, due: due});
        end
        if (inst_valid && inst_ready) begin
            check("deliver_pc", inst_pc, exp_pc);
            check("deliver_inst", inst, inst_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (redirect_valid) begin
            exp_fetch = {redirect_pc[31:2], 2'b00};
            exp_pc    = {redirect_pc[31:2], 2'b00};
        end
        @(posedge hclk);
        #1;
        cyc++;
    endtask

    // Run with inst_ready high until the head becomes valid; check its pc.
    task automatic wait_valid(input string name, input logic [31:0] want_pc);
        bit found = 1'b0;
        inst_ready = 1'b1;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (s_valid) begin
                found = 1'b1;
                check({name, "_pc"}, s_pc, want_pc);
                check({name, "_inst"}, s_inst, inst_of(want_pc));
            end
        end
        check({name, "_seen"}, found, 1);
    endtask

    typedef struct {
        bit          rst;
        bit          gnt;
        bit          ready;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[16];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int pops_start;

        // Stream from reset with 1-cycle memory, then backpressure with a single pop.
        //           rst gnt rdy  req  addr    vld  pc
        vecs[0]  = '{1, 1, 1,   1, 32'h00,  0, 32'h0};
        vecs[1]  = '{0, 1, 1,   1, 32'h04,  0, 32'h0};
        vecs[2]  = '{0, 1, 1,   1, 32'h08,  1, 32'h0};
        vecs[3]  = '{0, 1, 1,   1, 32'h0c,  1, 32'h4};
        vecs[4]  = '{0, 1, 1,   1, 32'h10,  1, 32'h8};
        vecs[5]  = '{0, 1, 1,   1, 32'h14,  1, 32'hc};
        vecs[6]  = '{1, 1, 0,   1, 32'h00,  0, 32'h0};
        vecs[7]  = '{0, 1, 0,   1, 32'h04,  0, 32'h0};
        vecs[8]  = '{0, 1, 0,   1, 32'h08,  1, 32'h0};
        vecs[9]  = '{0, 1, 0,   1, 32'h0c,  1, 32'h0};
        vecs[10] = '{0, 1, 0,   0, 32'h00,  1, 32'h0};
        vecs[11] = '{0, 1, 0,   0, 32'h00,  1, 32'h0};
        vecs[12] = '{0, 1, 1,   0, 32'h00,  1, 32'h0};
        vecs[13] = '{0, 1, 0,   1, 32'h10,  1, 32'h4};
        vecs[14] = '{0, 1, 0,   0, 32'h00,  1, 32'h4};
        vecs[15] = '{0, 1, 0,   0, 32'h00,  1, 32'h4};

        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rst) do_reset();
            imem_gnt   = vecs[i].gnt;
            inst_ready = vecs[i].ready;
            tick();
            check($sformatf("vec%0d_req", i), s_req, vecs[i].exp_req);
            if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), s_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_valid", i), s_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) check($sformatf("vec%0d_pc", i), s_pc, vecs[i].exp_pc);
        end

        // Redirect with two requests in flight on a 3-cycle memory.
        do_reset();
        lat_min = 3;
        lat_max = 3;
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        check("redirect_req_low", s_req, 0);
        redirect_valid = 1'b0;
        wait_valid("redirect_first", 32'h0000_0100);

        // Redirect, pop and response all in the same cycle.
        do_reset();
        lat_min = 1;
        lat_max = 1;
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        repeat (4) tick();
        pops_start     = pops;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        check("simul_pop_once", pops - pops_start, 1);
        redirect_valid = 1'b0;
        tick();
        check("simul_empty_after", s_valid, 0);
        wait_valid("simul_first", 32'h0000_0200);

        // Back-to-back redirects, the second coinciding with a response.
        do_reset();
        lat_min = 2;
        lat_max = 2;
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        redirect_pc    = 32'h0000_0402;
        tick();
        redirect_valid = 1'b0;
        wait_valid("b2b_first", 32'h0000_0400);

        // Asynchronous reset in the middle of a stream.
        do_reset();
        lat_min = 1;
        lat_max = 1;
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        repeat (4) tick();
        #2;
        check("pre_reset_valid", inst_valid, 1);
        reset = 1'b1;
        #1;
        check("reset_req_async", imem_req, 0);
        check("reset_valid_async", inst_valid, 0);
        do_reset();
        #1;
        check("restart_req", imem_req, 1);
        check("restart_addr", imem_addr, RESET_PC);
        imem_gnt = 1'b1;
        wait_valid("restart_first", RESET_PC);

        // Random grants, latencies, backpressure and redirects.
        do_reset();
        lat_min    = 1;
        lat_max    = 5;
        pops_start = pops;
        for (int i = 0; i < 3000; i++) begin
            imem_gnt       = ($urandom_range(99) < 70);
            inst_ready     = ($urandom_range(99) < 60);
            redirect_valid = ($urandom_range(99) < 3);
            redirect_pc    = $urandom;
            tick();
        end
        redirect_valid = 1'b0;
        check("random_progress", (pops - pops_start) > 500, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vscale_fetch_queue.md
VSCALE_FETCH_QUEUE -- requirements
Module: vscale_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two, at least 2.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning first fetch address.
REQ-004 Port hclk  in  1  clock; all state updates on rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Port redirect_valid  in  1  flush and restart fetch.
REQ-007 Port redirect_pc  in  XLEN  restart address; bits [1:0] ignored.
REQ-008 Port imem_req  out  1  fetch request.
REQ-009 Port imem_addr  out  XLEN  fetch address, word aligned.
REQ-010 Port imem_gnt  in  1  request accepted this cycle.
REQ-011 Port imem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after grant.
REQ-012 Port imem_rdata  in  XLEN  response instruction.
REQ-013 Port inst_valid  out  1  queue head valid.
REQ-014 Port inst  out  XLEN  head instruction.
REQ-015 Port inst_pc  out  XLEN  head instruction address.
REQ-016 Port inst_ready  in  1  consumer accepts head.

Function
REQ-017 fetch_pc SHALL advance by 4 on each cycle with imem_req && imem_gnt; imem_addr = fetch_pc.
REQ-018 imem_req SHALL be high iff !redirect_valid && (occupancy + inflight) < DEPTH, giving credit-based flow control so that the queue never overflows.
REQ-019 An unaccepted request SHALL hold imem_addr stable until granted, unless redirect_valid drops it.
REQ-020 inflight SHALL increment on grant and decrement on imem_rvalid; both in one cycle leave it unchanged.
REQ-021 On imem_rvalid with discard > 0, the data SHALL be dropped and discard decremented; otherwise {resp_pc, imem_rdata} SHALL be pushed and resp_pc advanced by 4.
REQ-022 Head SHALL be popped on inst_valid && inst_ready; push and pop in one cycle SHALL both occur.
REQ-023 The queue SHALL be registered: a pushed entry SHALL appear on inst_valid one cycle after imem_rvalid, with no bypass.
REQ-024 On redirect_valid, the block SHALL empty the queue after any same-cycle pop.
REQ-025 On redirect_valid, fetch_pc and resp_pc SHALL load {redirect_pc[XLEN-1:2], 2'b00}.
REQ-026 On redirect_valid, discard SHALL load inflight_next, so that every response still outstanding after that cycle is dropped.
REQ-027 A response arriving in the redirect cycle SHALL be consumed by the normal discard or push rule, and any push SHALL then be flushed.
REQ-028 Back-to-back redirects SHALL each restart fetch, with discard recomputed on each redirect.
REQ-029 Pointers SHALL wrap modulo DEPTH.
REQ-030 inflight and discard SHALL be $clog2(DEPTH)+1 bits wide.
REQ-031 inst and inst_pc SHALL be don't-care while inst_valid is low.

Reset
REQ-032 Asserting reset SHALL immediately clear inst_valid and imem_req.
REQ-033 Reset SHALL set fetch_pc = resp_pc = RESET_PC and set pointers, occupancy, inflight and discard to 0.
REQ-034 Responses to requests granted before reset are a system error; the memory SHALL be reset together with this block.
REQ-035 The first imem_req SHALL assert in the first cycle after reset deasserts.

Structure
REQ-036 The shared package vscale_pkg SHALL hold RV_NOP (32'h00000013) and the XLEN default.
REQ-037 Storage SHALL be one sub-module, vscale_sync_fifo (DEPTH x 2*XLEN, push/pop/flush, full/empty/count).
REQ-038 Assertions SHALL check: no push when full; discard <= inflight; imem_rvalid only when inflight > 0.

Verification
REQ-039 Stream test: 1-cycle-latency memory, inst_ready = 1 -> inst_pc sequence 0, 4, 8, ... with one instruction per cycle after a 2-cycle start-up.
REQ-040 Backpressure test: inst_ready = 0 -> exactly DEPTH (4) grants, then imem_req low; one pop -> exactly one further grant.
REQ-041 Redirect test: 3-cycle-latency memory; redirect to 0x100 with 2 in flight -> 2 responses dropped, and the next inst_pc is 0x100.
REQ-042 Simultaneous test: redirect, pop and imem_rvalid in one cycle -> queue empty next cycle, pop counted once, no stale PC delivered.
REQ-043 Reset test: assert reset mid-stream -> inst_valid and imem_req low asynchronously; after release, fetch restarts at RESET_PC.
REQ-044 Random test: random grant, latency 1-5, random ready and redirects -> delivered {pc, inst} matches the reference model, with no overflow assertion firing.
